// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte sources.
// Each grant covers one packet (or MAX_BURST bytes). The packet is preceded by a
// header byte {HDR_TAG, id} so the far end can demultiplex the channels.
//
// Handshake rule on every AXI-Stream port: a byte moves on a rising clk edge
// exactly when tvalid and tready are both high. A source never withdraws tvalid
// or changes tdata while tready is low. The arbiter holds the header stable
// under backpressure. During STREAM it is a pure combinational passthrough, so
// payload stability is inherited from the granted source.
module uart_tx_arbiter #(
   parameter int         NUM_REQ       = 4,
   parameter int         MAX_BURST     = 16,
   parameter int         STALL_TIMEOUT = 1024,
   parameter logic [3:0] HDR_TAG       = 4'hA
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ*8-1:0]       s_axis_tdata,
   input  logic [NUM_REQ-1:0]         s_axis_tvalid,
   input  logic [NUM_REQ-1:0]         s_axis_tlast,
   output logic [NUM_REQ-1:0]         s_axis_tready,
   output logic [7:0]                 m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);

   localparam int GW  = $clog2(NUM_REQ);
   localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int SCW = $clog2(STALL_TIMEOUT);

   localparam logic [BCW-1:0] BC_LAST  = BCW'(MAX_BURST - 1);
   localparam logic [SCW-1:0] SC_LAST  = SCW'(STALL_TIMEOUT - 1);
   localparam logic [GW-1:0]  LAST_RST = GW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HEADER = 2'd1,
      S_STREAM = 2'd2
   } state_t;

   state_t         r_state;
   logic [GW-1:0]  r_last_grant;
   logic [GW-1:0]  r_grant_id;
   logic [BCW-1:0] r_byte_cnt;
   logic [SCW-1:0] r_stall_cnt;
   logic           r_busy;

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [GW:0]          w_shamt;
   logic [NUM_REQ-1:0]   w_rot;
   logic                 w_found;
   logic [GW-1:0]        w_winner;

   logic                 w_g_valid;
   logic                 w_g_last;
   logic [7:0]           w_g_data;

   // Round-robin pick: rotate the request vector so that (last_grant+1) sits at
   // bit 0, then take the lowest set bit and map it back to a requester index.
   always_comb begin
      w_dbl    = {s_axis_tvalid, s_axis_tvalid};
      w_shamt  = {1'b0, r_last_grant} + (GW+1)'(1);
      w_rot    = NUM_REQ'(w_dbl >> w_shamt);
      w_found  = 1'b0;
      w_winner = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!w_found && w_rot[j]) begin
            w_found  = 1'b1;
            w_winner = GW'((int'(r_last_grant) + 1 + j) % NUM_REQ);
         end
      end
   end

   // Signals of the currently granted source.
   always_comb begin
      w_g_valid = s_axis_tvalid[r_grant_id];
      w_g_last  = s_axis_tlast[r_grant_id];
      w_g_data  = s_axis_tdata[r_grant_id*8 +: 8];
   end

   // Output muxing: idle is silent, header is a constant byte, stream is a passthrough.
   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = 8'h00;
      s_axis_tready = '0;
      case (r_state)
         S_HEADER: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = {HDR_TAG, 4'(r_grant_id)};
         end
         S_STREAM: begin
            m_axis_tvalid             = w_g_valid;
            m_axis_tdata              = w_g_data;
            s_axis_tready[r_grant_id] = m_axis_tready;
         end
         default: begin
         end
      endcase
   end

   // Control FSM: arbitrate, send header, stream until tlast, burst limit or stall timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= LAST_RST;
         r_grant_id   <= '0;
         r_byte_cnt   <= '0;
         r_stall_cnt  <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant_id <= w_winner;
                  r_state    <= S_HEADER;
                  r_busy     <= 1'b1;
               end
            end
            S_HEADER: begin
               if (m_axis_tready) begin
                  r_state     <= S_STREAM;
                  r_byte_cnt  <= '0;
                  r_stall_cnt <= '0;
               end
            end
            S_STREAM: begin
               if (w_g_valid && m_axis_tready) begin
                  r_stall_cnt <= '0;
                  if (w_g_last || (r_byte_cnt == BC_LAST)) begin
                     r_state      <= S_IDLE;
                     r_last_grant <= r_grant_id;
                     r_busy       <= 1'b0;
                  end else begin
                     r_byte_cnt <= r_byte_cnt + BCW'(1);
                  end
               end else if (!w_g_valid) begin
                  // Source went quiet mid-packet; give the link away once the budget is used up.
                  if (r_stall_cnt == SC_LAST) begin
                     r_state      <= S_IDLE;
                     r_last_grant <= r_grant_id;
                     r_busy       <= 1'b0;
                  end else begin
                     r_stall_cnt <= r_stall_cnt + SCW'(1);
                  end
               end
               // Valid but downstream not ready: hold everything, never time out.
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign grant_id = r_grant_id;
   assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-source byte queues feed the DUT, the output
// byte stream is collected and compared against a packet-level round-robin model.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int MAXB = 4;
   localparam int STO  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ*8-1:0] s_axis_tdata;
   logic [NREQ-1:0]   s_axis_tvalid;
   logic [NREQ-1:0]   s_axis_tlast;
   logic [NREQ-1:0]   s_axis_tready;
   logic [7:0]        m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [1:0]        grant_id;
   logic              busy;

   uart_tx_arbiter #(
      .NUM_REQ      (NREQ),
      .MAX_BURST    (MAXB),
      .STALL_TIMEOUT(STO),
      .HDR_TAG      (4'hA)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int         n_run;
   int         n_fail;
   logic [8:0] src_q [NREQ][$];   // {tlast, data}
   logic [7:0] obs_q [$];
   logic [7:0] exp_q [$];
   int         cyc_n;
   int         rdy_period;
   bit         rdy_rand;
   logic       prev_v;
   logic       prev_r;
   logic [7:0] prev_d;
   int         last_hs_cyc;

   function automatic bit all_empty();
      for (int i = 0; i < NREQ; i++)
         if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: drive after the edge, sample at the falling edge.
   task automatic cycle();
      logic [8:0] h;
      @(posedge clk);
      #1;
      cyc_n++;
      for (int i = 0; i < NREQ; i++) begin
         if (src_q[i].size() > 0) begin
            h = src_q[i][0];
            s_axis_tvalid[i]         = 1'b1;
            s_axis_tdata[i*8 +: 8]   = h[7:0];
            s_axis_tlast[i]          = h[8];
         end else begin
            s_axis_tvalid[i]         = 1'b0;
            s_axis_tdata[i*8 +: 8]   = 8'h00;
            s_axis_tlast[i]          = 1'b0;
         end
      end
      if (rdy_rand) m_axis_tready = ($urandom_range(0, 3) != 0);
      else          m_axis_tready = ((cyc_n % rdy_period) == 0);
      @(negedge clk);
      if (prev_v && !prev_r) begin
         n_run++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d) begin
            n_fail++;
            $display("FAIL hold_stable: tvalid=%b tdata=%h, required tvalid=1 tdata=%h",
                     m_axis_tvalid, m_axis_tdata, prev_d);
         end
      end
      n_run++;
      if ($countones(s_axis_tready) > 1) begin
         n_fail++;
         $display("FAIL tready_onehot: s_axis_tready=%b, required at most one bit", s_axis_tready);
      end
      for (int i = 0; i < NREQ; i++)
         if (s_axis_tvalid[i] && s_axis_tready[i]) void'(src_q[i].pop_front());
      if (m_axis_tvalid && m_axis_tready) begin
         obs_q.push_back(m_axis_tdata);
         last_hs_cyc = cyc_n;
      end
      prev_v = m_axis_tvalid;
      prev_r = m_axis_tready;
      prev_d = m_axis_tdata;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      s_axis_tlast  = '0;
      m_axis_tready = 1'b0;
      for (int i = 0; i < NREQ; i++) src_q[i].delete();
      obs_q.delete();
      exp_q.delete();
      prev_v     = 1'b0;
      rdy_period = 1;
      rdy_rand   = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic run_to_idle(input int budget, output bit timed_out);
      int c;
      c = 0;
      timed_out = 1'b0;
      while (!(c > 0 && all_empty() && busy === 1'b0 && obs_q.size() >= exp_q.size())) begin
         if (c >= budget) begin
            timed_out = 1'b1;
            break;
         end
         cycle();
         c++;
      end
   endtask

   // Packet-level reference: whole packets granted in round-robin order,
   // each prefixed by its header, cut after MAXB bytes.
   task automatic build_expected(input int last_g);
      logic [8:0] mq [NREQ][$];
      logic [8:0] e;
      int g, n, c;
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) mq[i] = src_q[i];
      forever begin
         g = -1;
         for (int k = 1; k <= NREQ; k++) begin
            c = (last_g + k) % NREQ;
            if (g < 0 && mq[c].size() > 0) g = c;
         end
         if (g < 0) break;
         exp_q.push_back(8'hA0 | 8'(g));
         n = 0;
         do begin
            e = mq[g].pop_front();
            exp_q.push_back(e[7:0]);
            n++;
         end while (!e[8] && n < MAXB && mq[g].size() > 0);
         last_g = g;
      end
   endtask

   task automatic push_random_packets(input int count);
      int s, len;
      for (int p = 0; p < count; p++) begin
         s   = $urandom_range(0, NREQ-1);
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++)
            src_q[s].push_back({(b == len-1), 8'($urandom_range(0, 255))});
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      s_axis_tvalid = '1;
      s_axis_tlast  = '1;
      m_axis_tready = 1'b1;
      #7;
      n_run++;
      if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid: got %b want 0", m_axis_tvalid); end
      n_run++;
      if (s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL reset_sready: got %b want 0000", s_axis_tready); end
      n_run++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_run++;
      if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
      do_reset();
   endtask

   task automatic test_single();
      int guard;
      do_reset();
      src_q[1].push_back({1'b0, 8'h11});
      src_q[1].push_back({1'b0, 8'h22});
      src_q[1].push_back({1'b1, 8'h33});
      cycle();
      n_run++;
      if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
         n_fail++; $display("FAIL single_arb_cycle: busy=%b tvalid=%b want 0 0", busy, m_axis_tvalid);
      end
      cycle();
      n_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA1) begin
         n_fail++; $display("FAIL single_header: tvalid=%b tdata=%h want 1 a1", m_axis_tvalid, m_axis_tdata);
      end
      guard = 0;
      while (src_q[1].size() > 0 && guard < 50) begin cycle(); guard++; end
      cycle();
      n_run++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b want 0", busy); end
      n_run++;
      if (grant_id !== 2'd1) begin n_fail++; $display("FAIL single_grant: got %0d want 1", grant_id); end
      exp_q = '{8'hA1, 8'h11, 8'h22, 8'h33};
      n_run++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL single_len: got %0d bytes want %0d", obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_run++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL single_byte[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_round_robin();
      bit to;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         src_q[0].push_back({1'b1, 8'($urandom_range(0, 255))});
         src_q[2].push_back({1'b1, 8'($urandom_range(0, 255))});
         src_q[3].push_back({1'b1, 8'($urandom_range(0, 255))});
      end
      build_expected(NREQ-1);
      run_to_idle(500, to);
      n_run++;
      if (to || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rr_len: got %0d bytes want %0d timeout=%0b", obs_q.size(), exp_q.size(), to);
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_run++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rr_byte[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_burst_cut();
      bit to;
      do_reset();
      for (int b = 0; b < 6; b++) src_q[0].push_back({(b == 5), 8'(8'h40 + b)});
      build_expected(NREQ-1);
      run_to_idle(500, to);
      n_run++;
      if (to || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL burst_len: got %0d bytes want %0d timeout=%0b", obs_q.size(), exp_q.size(), to);
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_run++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL burst_byte[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
      n_run++;
      if (obs_q.size() < 6 || obs_q[5] !== 8'hA0) begin
         n_fail++; $display("FAIL burst_second_header: size=%0d, required byte 5 = a0", obs_q.size());
      end
   endtask

   task automatic test_backpressure(input int period);
      bit to;
      do_reset();
      rdy_period = period;
      push_random_packets(8);
      build_expected(NREQ-1);
      run_to_idle(4000, to);
      n_run++;
      if (to || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL bp%0d_len: got %0d bytes want %0d timeout=%0b", period, obs_q.size(), exp_q.size(), to);
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_run++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp%0d_byte[%0d]: got %h want %h", period, k, obs_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_stall();
      bit to;
      int guard, n0;
      logic [7:0] b2, b0;
      do_reset();
      b2 = 8'($urandom_range(0, 255));
      b0 = 8'($urandom_range(0, 255));
      src_q[2].push_back({1'b0, b2});
      guard = 0;
      while (obs_q.size() < 1 && guard < 50) begin cycle(); guard++; end
      src_q[0].push_back({1'b1, b0});
      while (obs_q.size() < 2 && guard < 100) begin cycle(); guard++; end
      n0 = last_hs_cyc;
      while (cyc_n < n0 + STO && guard < 200) begin cycle(); guard++; end
      n_run++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_still_granted: busy=%b want 1", busy); end
      cycle();
      n_run++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_revoked: busy=%b want 0", busy); end
      exp_q = '{8'hA2, b2, 8'hA0, b0};
      run_to_idle(200, to);
      n_run++;
      if (to || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL stall_len: got %0d bytes want %0d timeout=%0b", obs_q.size(), exp_q.size(), to);
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_run++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL stall_byte[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int guard;
      do_reset();
      for (int b = 0; b < 5; b++) src_q[1].push_back({(b == 4), 8'(8'h60 + b)});
      guard = 0;
      while (obs_q.size() < 3 && guard < 50) begin cycle(); guard++; end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      n_run++;
      if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_mvalid: got %b want 0", m_axis_tvalid); end
      n_run++;
      if (s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL rstmid_sready: got %b want 0000", s_axis_tready); end
      n_run++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      s_axis_tvalid = '0;
      @(posedge clk);
      #2;
      rst    = 1'b0;
      prev_v = 1'b0;
      obs_q.delete();
      src_q[0].push_back({1'b0, 8'h71});
      src_q[0].push_back({1'b1, 8'h72});
      build_expected(NREQ-1);
      run_to_idle(500, to);
      n_run++;
      if (to || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rstmid_len: got %0d bytes want %0d timeout=%0b", obs_q.size(), exp_q.size(), to);
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_run++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rstmid_byte[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_random();
      bit to;
      do_reset();
      rdy_rand = 1'b1;
      push_random_packets(14);
      build_expected(NREQ-1);
      run_to_idle(4000, to);
      n_run++;
      if (to || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rand_len: got %0d bytes want %0d timeout=%0b", obs_q.size(), exp_q.size(), to);
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_run++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_byte[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
      rdy_rand = 1'b0;
   endtask

   initial begin
      n_run         = 0;
      n_fail        = 0;
      cyc_n         = 0;
      last_hs_cyc   = 0;
      rdy_period    = 1;
      rdy_rand      = 1'b0;
      prev_v        = 1'b0;
      prev_r        = 1'b0;
      prev_d        = 8'h00;
      rst           = 1'b1;
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      s_axis_tlast  = '0;
      m_axis_tready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_burst_cut();
      test_backpressure(4);
      test_backpressure(12);
      test_stall();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ AXI-Stream byte sources using round-robin arbitration.
- A grant lasts for one packet. Each granted packet is preceded by a one-byte channel header so the host can demultiplex.
- Sits between the per-source byte producers and the uart_tx AXI-Stream input (m_axis). It is the link-side counterpart of uart_rx.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16 (the ID must fit in a 4-bit header field).
- MAX_BURST, 16, maximum payload bytes per grant; the grant is released after this many even if tlast is never seen; legal range ≥1.
- STALL_TIMEOUT, 1024, cycles the granted source may hold tvalid low mid-packet before its grant is revoked; legal range ≥2.
- HDR_TAG, 4'hA, upper nibble of the header byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NUM_REQ*8  byte from each requester; requester i uses bits [8i+7:8i].
- s_axis_tvalid  in  NUM_REQ  per-requester valid.
- s_axis_tlast  in  NUM_REQ  per-requester end-of-packet marker.
- s_axis_tready  out  NUM_REQ  per-requester ready.
- m_axis_tdata  out  8  byte to the UART transmitter.
- m_axis_tvalid  out  1  valid to the UART transmitter.
- m_axis_tready  in  1  ready from the UART transmitter.
- grant_id  out  $clog2(NUM_REQ)  currently or most recently granted requester.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, any state, any time):
  - state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), grant_id=0, byte_cnt=0, stall_cnt=0.
  - m_axis_tvalid=0, s_axis_tready=0, busy=0.
  - A packet interrupted by reset is abandoned; no tail bytes are emitted after reset deasserts.
- States: IDLE, HEADER, STREAM.
- IDLE:
  - m_axis_tvalid=0 and all s_axis_tready=0.
  - If any s_axis_tvalid is high, the winner is the first requester with tvalid high, scanning from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - On the next edge: grant_id<=winner, state<=HEADER.
  - Arbitration latency is 1 cycle from request to header valid.
- HEADER:
  - m_axis_tvalid=1 and m_axis_tdata={HDR_TAG, grant_id zero-extended to 4 bits}; all s_axis_tready=0.
  - When m_axis_tready=1: state<=STREAM, byte_cnt<=0, stall_cnt<=0.
  - The header is held stable while tready is low (AXI rule: valid is never withdrawn).
- STREAM:
  - Combinational passthrough of the granted channel g=grant_id: m_axis_tdata=s_axis_tdata[g], m_axis_tvalid=s_axis_tvalid[g], s_axis_tready[g]=m_axis_tready. All other s_axis_tready=0.
  - On a handshake (valid & ready):
    - stall_cnt<=0.
    - If s_axis_tlast[g]=1 or byte_cnt==MAX_BURST-1: state<=IDLE, last_grant<=g.
    - Otherwise byte_cnt<=byte_cnt+1.
  - While s_axis_tvalid[g]=0: stall_cnt increments. When stall_cnt reaches STALL_TIMEOUT-1: state<=IDLE, last_grant<=g (grant revoked, no byte lost).
  - If m_axis_tready is low while the source is valid, stall_cnt does not count; downstream backpressure never revokes a grant.
- Requests from other channels during HEADER/STREAM are ignored until the return to IDLE.
- Back-to-back packets cost 1 idle cycle between them (STREAM→IDLE→HEADER).
- Simultaneous tlast and byte_cnt==MAX_BURST-1: a single release; the behaviour is identical to either condition alone.
- Counter widths: byte_cnt is $clog2(MAX_BURST) bits (minimum 1); stall_cnt is $clog2(STALL_TIMEOUT) bits. Neither counter may wrap.
- grant_id holds its last value in IDLE.

Test Plan:
- Single source:
  - Stimulus: req1 sends 3 bytes 0x11,0x22,0x33 (tlast on 0x33), m_axis_tready=1 throughout.
  - Required: m stream is A1,11,22,33; busy drops on the cycle after the 0x33 handshake; grant_id=1.
- Round-robin fairness:
  - Stimulus: req0, req2 and req3 all continuously valid with 1-byte packets (tlast=1).
  - Required: header order A0,A2,A3,A0,A2,...; no requester is served twice while another is waiting.
- MAX_BURST cut:
  - Stimulus: MAX_BURST=4; req0 sends 6 bytes with tlast only on byte 6.
  - Required: A0 plus 4 bytes, then A0 plus the remaining 2 bytes (assuming no other requests).
- Backpressure:
  - Stimulus: m_axis_tready toggles 1-on/3-off during both header and payload.
  - Required: tdata stays stable while tvalid=1 & tready=0; no duplicated or dropped bytes; no timeout.
- Stall timeout:
  - Stimulus: STALL_TIMEOUT=8; req2 sends 1 byte without tlast, then drops tvalid; req0 is waiting.
  - Required: 8 cycles later the grant is revoked and the next header is A0.
- Reset mid-packet:
  - Stimulus: assert rst asynchronously during STREAM after 2 bytes.
  - Required: m_axis_tvalid=0 and s_axis_tready=0 immediately; after release the first serviced request (req0 priority) begins with a header.
